sr_fifo: RTL and testbench

//  - First-word-fall-through data FIFO that the core's PUSH/POP custom instructions use.
//  - PUSH (from sr_control fifoPush) writes rs1 or the immediate into the FIFO.
//  - POP (wdSrc==2'b10) writes the head word into the register file in the same cycle.
//  - The head word is therefore presented combinationally on dout; pop only advances the read pointer at the clock edge.

---
 rtl/sr_fifo_pkg.sv | 5 +
 rtl/sr_fifo_ptr.sv | 16 +
 rtl/sr_fifo.sv | 54 +++++
 tb/tb_sr_fifo.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sr_fifo_pkg.sv
// sr_fifo_pkg: shared FIFO defaults for sr_cpu and sr_fifo.
package sr_fifo_pkg;
    localparam int SR_FIFO_WIDTH = 16;
    localparam int SR_FIFO_DEPTH = 8;
endpackage

// File: rtl/sr_fifo_ptr.sv
// sr_fifo_ptr: FIFO pointer that wraps from DEPTH-1 to 0 for any depth.
module sr_fifo_ptr #(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
endmodule

// File: rtl/sr_fifo.sv
// sr_fifo: first-word-fall-through FIFO behind the PUSH/POP instructions.
module sr_fifo
    import sr_fifo_pkg::*;
#(
    parameter int WIDTH = SR_FIFO_WIDTH,
    parameter int DEPTH = SR_FIFO_DEPTH,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             udf
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdPtr, wrPtr;
    logic             doPop, doPush;

    assign empty  = count == '0;
    assign full   = count == CW'(DEPTH);
    assign doPop  = ~clr & pop & ~empty;
    assign doPush = ~clr & push & (~full | doPop);
    // Head is driven without a bypass so POP writeback never stalls.
    assign dout   = empty ? '0 : mem[rdPtr];

    sr_fifo_ptr #(.DEPTH(DEPTH)) uRdPtr (.clk(clk), .rst(rst), .clr(clr), .inc(doPop),  .ptr(rdPtr));
    sr_fifo_ptr #(.DEPTH(DEPTH)) uWrPtr (.clk(clk), .rst(rst), .clr(clr), .inc(doPush), .ptr(wrPtr));

    always_ff @(posedge clk)
        if (doPush) mem[wrPtr] <= din;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            count <= count + CW'(doPush) - CW'(doPop);
            if (push & full & ~doPop) ovf <= 1'b1;
            if (pop & empty) udf <= 1'b1;
        end
endmodule

// File: tb/tb_sr_fifo.sv
// tb_sr_fifo: directed checks of sr_fifo at DEPTH=8 (instance A) and DEPTH=5 (instance B).
module tb_sr_fifo;
    logic        clk = 1'b0, rst = 1'b1;
    logic        clrA = 0, pushA = 0, popA = 0, clrB = 0, pushB = 0, popB = 0;
    logic [15:0] dinA = '0, dinB = '0, doutA, doutB;
    logic        emptyA, fullA, ovfA, udfA, emptyB, fullB, ovfB, udfB;
    logic [3:0]  countA;
    logic [2:0]  countB;
    int          nAsserts = 0, nFails = 0;

    always #5 clk = ~clk;

    sr_fifo #(.WIDTH(16), .DEPTH(8)) dutA (
        .clk(clk), .rst(rst), .clr(clrA), .push(pushA), .din(dinA), .pop(popA),
        .dout(doutA), .empty(emptyA), .full(fullA), .count(countA), .ovf(ovfA), .udf(udfA));
    sr_fifo #(.WIDTH(16), .DEPTH(5)) dutB (
        .clk(clk), .rst(rst), .clr(clrB), .push(pushB), .din(dinB), .pop(popB),
        .dout(doutB), .empty(emptyB), .full(fullB), .count(countB), .ovf(ovfB), .udf(udfB));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held: activity must not disturb either instance
        for (int i = 0; i < 4; i++) begin
            pushA = i[0]; popA = i[1]; dinA = 16'(i + 16'h40);
            pushB = i[0]; popB = i[1]; dinB = 16'(i + 16'h50);
            tick();
            chk("rst_empty", {emptyA, emptyB}, 2'b11);
            chk("rst_full", {fullA, fullB}, 2'b00);
            chk("rst_count", {countA, 1'b0, countB}, 8'h00);
            chk("rst_dout", {doutA, doutB}, 32'h0);
            chk("rst_flags", {ovfA, udfA, ovfB, udfB}, 4'b0000);
        end
        pushA = 0; popA = 0; pushB = 0; popB = 0;
        rst = 0;
        tick();
        // Fill and drain
        for (int i = 1; i <= 8; i++) begin
            pushA = 1; dinA = 16'(i);
            tick();
        end
        pushA = 0;
        chk("fill_full", fullA, 1'b1);
        chk("fill_count", countA, 4'd8);
        for (int i = 1; i <= 8; i++) begin
            popA = 1;
            chk("drain_dout", doutA, 32'(i));
            tick();
        end
        popA = 0;
        chk("drain_empty", emptyA, 1'b1);
        chk("drain_dout0", doutA, 32'h0);
        chk("drain_count", countA, 4'd0);
        chk("drain_udf", udfA, 1'b0);
        // Overflow, then push+pop while full
        for (int i = 1; i <= 8; i++) begin
            pushA = 1; dinA = 16'(i);
            tick();
        end
        dinA = 16'hBEEF;
        tick();
        pushA = 0;
        chk("ovf_count", countA, 4'd8);
        chk("ovf_flag", ovfA, 1'b1);
        chk("ovf_head", doutA, 32'h1);
        pushA = 1; popA = 1; dinA = 16'h1234;
        chk("pp_full_head", doutA, 32'h1);
        tick();
        pushA = 0; popA = 0;
        chk("pp_full_count", countA, 4'd8);
        chk("pp_full_full", fullA, 1'b1);
        for (int i = 0; i < 8; i++) begin
            popA = 1;
            chk("pp_drain_dout", doutA, (i < 7) ? 32'(i + 2) : 32'h1234);
            tick();
        end
        popA = 0;
        chk("pp_drain_empty", emptyA, 1'b1);
        // Push+pop on empty
        pushA = 1; popA = 1; dinA = 16'h00AA;
        #1;
        chk("epp_dout_same", doutA, 32'h0);
        tick();
        pushA = 0; popA = 0;
        chk("epp_udf", udfA, 1'b1);
        chk("epp_count", countA, 4'd1);
        chk("epp_dout_next", doutA, 32'h00AA);
        chk("epp_ovf_sticky", ovfA, 1'b1);
        // Wrap-around on DEPTH=5 at occupancy 2
        for (int i = 0; i < 2; i++) begin
            pushB = 1; dinB = 16'(16'h100 + i);
            tick();
        end
        for (int k = 0; k < 13; k++) begin
            pushB = 1; popB = 1; dinB = 16'(16'h102 + k);
            chk("wrap_dout", doutB, 32'(16'h100 + k));
            tick();
            chk("wrap_count", countB, 3'd2);
        end
        pushB = 0; popB = 0;
        for (int i = 0; i < 2; i++) begin
            popB = 1;
            chk("wrap_tail", doutB, 32'(16'h10D + i));
            tick();
        end
        popB = 0;
        chk("wrap_empty", emptyB, 1'b1);
        chk("wrap_flags", {ovfB, udfB}, 2'b00);
        // Flush with a concurrent push at count 3
        for (int i = 0; i < 2; i++) begin
            pushA = 1; dinA = 16'(16'h200 + i);
            tick();
        end
        chk("clr_pre_count", countA, 4'd3);
        pushA = 1; clrA = 1; dinA = 16'h0055;
        tick();
        pushA = 0; clrA = 0;
        chk("clr_count", countA, 4'd0);
        chk("clr_empty", emptyA, 1'b1);
        chk("clr_flags", {ovfA, udfA}, 2'b00);
        chk("clr_dout", doutA, 32'h0);
        // Async reset between edges
        for (int i = 0; i < 2; i++) begin
            pushA = 1; dinA = 16'(16'h300 + i);
            tick();
        end
        pushA = 0;
        chk("arst_pre_count", countA, 4'd2);
        #2;
        rst = 1;
        #1;
        chk("arst_count", countA, 4'd0);
        chk("arst_empty", emptyA, 1'b1);
        chk("arst_dout", doutA, 32'h0);
        rst = 0;
        tick();
        chk("arst_after", {emptyA, fullA}, 2'b10);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
